// File: rtl/req_arbiter_8_v.sv
// Eight-way request arbiter: fixed-priority or round-robin selection, registered
// one-hot grant held until the owner releases, withdraws, or the hold timer expires.
module req_arbiter_8_v #(
    parameter int TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req,
    input  logic       i_mode,
    input  logic       i_done,
    output logic [7:0] o_gnt,
    output logic [2:0] o_gnt_idx,
    output logic       o_valid,
    output logic       o_timeout
);

    localparam logic       TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q;
    logic [7:0] gnt_q;
    logic [2:0] idx_q;
    logic       valid_q;
    logic       timeout_q;
    logic [2:0] ptr_q;
    logic [7:0] cnt_q;

    logic [7:0] req_rot_d;
    logic [2:0] fix_win_d;
    logic [2:0] rot_win_d;
    logic [2:0] win_d;
    logic       rel_wd_d;
    logic       rel_to_d;
    logic       release_d;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Rotating the request vector so the pointer sits at bit 0 turns the
    // wrap-around search into a plain lowest-bit search.
    always_comb begin
        req_rot_d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            req_rot_d[i] = i_req[3'(i) + ptr_q];
        end
        fix_win_d = lowest_set(i_req);
        rot_win_d = lowest_set(req_rot_d) + ptr_q;
        win_d     = i_mode ? rot_win_d : fix_win_d;
        rel_wd_d  = !i_req[idx_q];
        rel_to_d  = TO_EN && (cnt_q == TO_LAST);
        release_d = i_done || rel_wd_d || rel_to_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            gnt_q     <= 8'd0;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 3'd0;
            cnt_q     <= 8'd0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|i_req) begin
                        state_q <= GRANT;
                        gnt_q   <= 8'd1 << win_d;
                        idx_q   <= win_d;
                        valid_q <= 1'b1;
                        cnt_q   <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q   <= IDLE;
                        gnt_q     <= 8'd0;
                        idx_q     <= 3'd0;
                        valid_q   <= 1'b0;
                        cnt_q     <= 8'd0;
                        ptr_q     <= idx_q + 3'd1;
                        // Only a pure timer expiry counts as a forced revoke.
                        timeout_q <= rel_to_d && !i_done && !rel_wd_d;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_idx = idx_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_req_arbiter_8_v.sv
// Bench for req_arbiter_8_v: directed test-plan steps followed by random traffic,
// all checked against a grant-owner reference model.
module tb_req_arbiter_8_v;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mode;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       valid;
    logic       tmo;

    req_arbiter_8_v #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_mode   (mode),
        .i_done   (done),
        .o_gnt    (gnt),
        .o_gnt_idx(gnt_idx),
        .o_valid  (valid),
        .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: who owns the resource (-1 = nobody), how many cycles
    // the current grant has been visible, where the round-robin search starts.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_ptr   = 0;
    logic m_to    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input logic m);
        int j;
        for (int k = 0; k < 8; k++) begin
            j = m ? (m_ptr + k) % 8 : k;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model(input logic [7:0] r, input logic m, input logic d, input logic rs);
        logic wd, tx;
        if (rs) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (r != 8'd0) begin
                m_owner = pick(r, m);
                m_held  = 1;
            end
        end else begin
            wd = !r[m_owner];
            tx = (TIMEOUT != 0) && (m_held == TIMEOUT);
            if (d || wd || tx) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_held  = 0;
                m_to    = tx && !d && !wd;
            end else begin
                m_held++;
                m_to = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic m, input logic d, input logic rs);
        logic [7:0] eg;
        req = r; mode = m; done = d; rst = rs;
        model(r, m, d, rs);
        @(posedge clk);
        #1;
        eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        chk("gnt",     {24'd0, gnt},     {24'd0, eg});
        chk("gnt_idx", {29'd0, gnt_idx}, (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("valid",   {31'd0, valid},   (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("timeout", {31'd0, tmo},     {31'd0, m_to});
    endtask

    initial begin
        logic [7:0] r;
        clk = 1'b0; rst = 1'b0; req = 8'd0; mode = 1'b0; done = 1'b0;

        // Reset and quiet bus
        step(8'd0, 1'b0, 1'b0, 1'b1);
        step(8'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_gnt",   {24'd0, gnt},   32'd0);
        for (int i = 0; i < 5; i++) step(8'd0, 1'b0, 1'b0, 1'b0);
        chk("idle_valid", {31'd0, valid}, 32'd0);

        // Fixed priority, release by done on the 3rd grant cycle
        step(8'b1010_0100, 1'b0, 1'b0, 1'b0);
        chk("fix_gnt", {24'd0, gnt}, 32'h04);
        chk("fix_idx", {29'd0, gnt_idx}, 32'd2);
        step(8'b1010_0100, 1'b0, 1'b0, 1'b0);
        step(8'b1010_0100, 1'b0, 1'b0, 1'b0);
        step(8'b1010_0100, 1'b0, 1'b1, 1'b0);
        chk("fix_rel_valid", {31'd0, valid}, 32'd0);
        step(8'b1010_0100, 1'b0, 1'b0, 1'b0);
        chk("fix_regrant_idx", {29'd0, gnt_idx}, 32'd2);
        step(8'd0, 1'b0, 1'b1, 1'b0);

        // Round-robin fairness from pointer 0
        step(8'd0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b1, 1'b0, 1'b0);
            chk("rr_idx", {29'd0, gnt_idx}, 32'(k % 8));
            step(8'hFF, 1'b1, 1'b1, 1'b0);
            chk("rr_bubble", {31'd0, valid}, 32'd0);
        end

        // Timeout: 16 held cycles, one pulse, re-grant after the bubble
        step(8'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < TIMEOUT; k++) begin
            step(8'h80, 1'b0, 1'b0, 1'b0);
            chk("to_hold_valid", {31'd0, valid}, 32'd1);
        end
        step(8'h80, 1'b0, 1'b0, 1'b0);
        chk("to_rel_valid", {31'd0, valid}, 32'd0);
        chk("to_pulse",     {31'd0, tmo},   32'd1);
        step(8'h80, 1'b0, 1'b0, 1'b0);
        chk("to_regrant_idx", {29'd0, gnt_idx}, 32'd7);
        chk("to_pulse_end",   {31'd0, tmo},     32'd0);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        // Round-robin wrap from pointer 6
        step(8'd0, 1'b1, 1'b0, 1'b1);
        step(8'h20, 1'b1, 1'b0, 1'b0);
        step(8'h20, 1'b1, 1'b1, 1'b0);
        step(8'h03, 1'b1, 1'b0, 1'b0);
        chk("wrap_idx", {29'd0, gnt_idx}, 32'd0);
        step(8'h00, 1'b1, 1'b0, 1'b0);

        // Owner 3 withdraws mid-grant
        step(8'h08, 1'b0, 1'b0, 1'b0);
        chk("wd_idx", {29'd0, gnt_idx}, 32'd3);
        step(8'h08, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("wd_valid", {31'd0, valid}, 32'd0);
        chk("wd_no_to", {31'd0, tmo},   32'd0);

        // Reset mid-grant drops everything and clears the pointer
        step(8'h10, 1'b1, 1'b0, 1'b0);
        step(8'h10, 1'b1, 1'b0, 1'b0);
        step(8'h10, 1'b1, 1'b0, 1'b1);
        chk("rstg_valid", {31'd0, valid}, 32'd0);
        chk("rstg_to",    {31'd0, tmo},   32'd0);
        step(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("rstg_ptr_idx", {29'd0, gnt_idx}, 32'd0);

        // Random traffic; requests mostly persist so grants can run long
        r = 8'hFF;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) r = 8'($urandom);
            step(r, 1'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
